// File: rtl/ii_enable_sequencer_pkg.sv
// Shared helpers for enable sequencers: counter width sizing and parameter range checks.
package ii_seq_pkg;

  // Width of a cooldown counter that must hold n-1; never narrower than one bit.
  function automatic int unsigned cntw(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit param_ge(input int unsigned val, input int unsigned min_val);
    return val >= min_val;
  endfunction

endpackage

// File: rtl/ii_enable_sequencer_if.sv
// Producer-facing handshake and status bundle of the enable sequencer.
interface ii_enable_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned InflW = $clog2(DEPTH + 1);

  logic             go;
  logic             clear_violation;
  logic             ready;
  logic [DEPTH-1:0] en;
  logic             done;
  logic             busy;
  logic [InflW-1:0] inflight;
  logic             violation;

  modport master (
    output go, clear_violation,
    input  ready, en, done, busy, inflight, violation
  );

  modport slave (
    input  go, clear_violation,
    output ready, en, done, busy, inflight, violation
  );
endinterface

// File: rtl/ii_enable_sequencer_cooldown.sv
// Initiation-interval cooldown: blocks new accepts for II-1 cycles after each one.
module ii_cooldown
  import ii_seq_pkg::*;
#(
  parameter int unsigned II = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic ready
);
  localparam int unsigned CntW = cntw(II);
  localparam logic [CntW-1:0] Reload = CntW'(II - 1);

  if (!param_ge(II, 1)) begin : g_bad_ii
    $error("ii_cooldown: II must be >= 1");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = Reload;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ready = (cnt_q == '0) && !reset;

endmodule

// File: rtl/ii_enable_sequencer.sv
// Turns accepted go strobes into tokens walking a DEPTH-stage chain of write enables.
module ii_enable_sequencer
  import ii_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned II    = 1
) (
  input logic                  clk,
  input logic                  reset,
  ii_enable_sequencer_if.slave bus_io
);
  localparam int unsigned InflW = $clog2(DEPTH + 1);

  if (!param_ge(DEPTH, 1)) begin : g_bad_depth
    $error("ii_enable_sequencer: DEPTH must be >= 1");
  end

  logic             ready;
  logic             accept;
  logic [DEPTH-1:0] tok_q, tok_d;
  logic [DEPTH-1:0] en;
  logic [InflW-1:0] inflight_q, inflight_d;
  logic             violation_q, violation_d;

  ii_cooldown #(
    .II(II)
  ) u_cooldown (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .ready (ready)
  );

  assign accept = bus_io.go & ready;

  always_comb begin
    tok_d    = tok_q;
    tok_d[0] = accept;
    for (int i = 1; i < DEPTH; i++) begin
      tok_d[i] = tok_q[i-1];
    end

    // Stage outputs are forced low while reset is held, even for tokens still in the chain.
    en = '0;
    if (!reset) begin
      en[0] = accept;
      for (int i = 1; i < DEPTH; i++) begin
        en[i] = tok_q[i-1];
      end
    end

    inflight_d = inflight_q;
    case ({accept, tok_q[DEPTH-1]})
      2'b10:   inflight_d = inflight_q + InflW'(1);
      2'b01:   inflight_d = inflight_q - InflW'(1);
      default: inflight_d = inflight_q;
    endcase

    violation_d = violation_q;
    if (bus_io.go && !ready && !reset) begin
      violation_d = 1'b1;
    end else if (bus_io.clear_violation) begin
      violation_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tok_q       <= '0;
      inflight_q  <= '0;
      violation_q <= 1'b0;
    end else begin
      tok_q       <= tok_d;
      inflight_q  <= inflight_d;
      violation_q <= violation_d;
    end
  end

  assign bus_io.ready     = ready;
  assign bus_io.en        = en;
  assign bus_io.done      = tok_q[DEPTH-1] & ~reset;
  assign bus_io.busy      = (accept | (|tok_q)) & ~reset;
  assign bus_io.inflight  = inflight_q;
  assign bus_io.violation = violation_q;

endmodule

// File: tb/tb_ii_enable_sequencer.sv
// Directed bench: three sequencer configurations driven cycle by cycle against hand-built tables.
module tb_ii_enable_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ii_enable_sequencer_if #(.DEPTH(4)) bus_a ();
  ii_enable_sequencer_if #(.DEPTH(4)) bus_b ();
  ii_enable_sequencer_if #(.DEPTH(1)) bus_c ();

  ii_enable_sequencer #(.DEPTH(4), .II(1)) u_dut_a (.clk(clk), .reset(reset), .bus_io(bus_a));
  ii_enable_sequencer #(.DEPTH(4), .II(3)) u_dut_b (.clk(clk), .reset(reset), .bus_io(bus_b));
  ii_enable_sequencer #(.DEPTH(1), .II(2)) u_dut_c (.clk(clk), .reset(reset), .bus_io(bus_c));

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus_a.go = 1'b1;
    step();
    step();
    @(negedge clk);
    total++; if (bus_a.ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus_a.ready); end
    total++; if (bus_a.en !== 4'h0) begin bad++; $display("FAIL rst_en got=%h want=0", bus_a.en); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus_a.done); end
    total++; if (bus_a.inflight !== 3'd0) begin bad++; $display("FAIL rst_inflight got=%0d want=0", bus_a.inflight); end
    total++; if (bus_a.violation !== 1'b0) begin bad++; $display("FAIL rst_viol got=%b want=0", bus_a.violation); end
    total++; if (bus_b.inflight !== 3'd0) begin bad++; $display("FAIL rst_b_inflight got=%0d want=0", bus_b.inflight); end
    total++; if (bus_c.inflight !== 1'b0) begin bad++; $display("FAIL rst_c_inflight got=%0d want=0", bus_c.inflight); end
    step();
    reset    = 1'b0;
    bus_a.go = 1'b0;
    @(negedge clk);
    total++; if (bus_a.ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b want=1", bus_a.ready); end
    total++; if (bus_a.violation !== 1'b0) begin bad++; $display("FAIL rel_viol got=%b want=0", bus_a.violation); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b want=0", bus_a.busy); end
    step();
  endtask

  task automatic test_single_token();
    bit [3:0] exp_en   [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    bit       exp_done [6] = '{0, 0, 0, 0, 1, 0};
    bit       exp_busy [6] = '{1, 1, 1, 1, 1, 0};
    int       exp_inf  [6] = '{0, 1, 1, 1, 1, 0};
    for (int c = 0; c < 6; c++) begin
      bus_a.go = (c == 0);
      @(negedge clk);
      total++; if (bus_a.en !== exp_en[c]) begin bad++; $display("FAIL single_en c%0d got=%h want=%h", c, bus_a.en, exp_en[c]); end
      total++; if (bus_a.done !== exp_done[c]) begin bad++; $display("FAIL single_done c%0d got=%b want=%b", c, bus_a.done, exp_done[c]); end
      total++; if (bus_a.busy !== exp_busy[c]) begin bad++; $display("FAIL single_busy c%0d got=%b want=%b", c, bus_a.busy, exp_busy[c]); end
      total++; if (bus_a.inflight !== 3'(exp_inf[c])) begin bad++; $display("FAIL single_inflight c%0d got=%0d want=%0d", c, bus_a.inflight, exp_inf[c]); end
      total++; if (bus_a.ready !== 1'b1) begin bad++; $display("FAIL single_ready c%0d got=%b want=1", c, bus_a.ready); end
      step();
    end
    bus_a.go = 1'b0;
  endtask

  task automatic test_ii_spacing();
    bit exp_go   [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
    bit exp_rdy  [8] = '{1, 0, 0, 1, 0, 0, 1, 1};
    bit exp_acc  [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    bit exp_done [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    bit exp_viol [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    for (int c = 0; c < 8; c++) begin
      bus_b.go = exp_go[c];
      @(negedge clk);
      total++; if (bus_b.ready !== exp_rdy[c]) begin bad++; $display("FAIL ii_ready c%0d got=%b want=%b", c, bus_b.ready, exp_rdy[c]); end
      total++; if (bus_b.en[0] !== exp_acc[c]) begin bad++; $display("FAIL ii_en0 c%0d got=%b want=%b", c, bus_b.en[0], exp_acc[c]); end
      total++; if (bus_b.done !== exp_done[c]) begin bad++; $display("FAIL ii_done c%0d got=%b want=%b", c, bus_b.done, exp_done[c]); end
      total++; if (bus_b.violation !== exp_viol[c]) begin bad++; $display("FAIL ii_viol c%0d got=%b want=%b", c, bus_b.violation, exp_viol[c]); end
      step();
    end
    bus_b.go = 1'b0;
  endtask

  task automatic test_violation_clear();
    bus_b.go = 1'b1;
    @(negedge clk);
    total++; if (bus_b.en[0] !== 1'b1) begin bad++; $display("FAIL vc_accept got=%b want=1", bus_b.en[0]); end
    step();
    bus_b.clear_violation = 1'b1;
    @(negedge clk);
    total++; if (bus_b.en[0] !== 1'b0) begin bad++; $display("FAIL vc_rejected got=%b want=0", bus_b.en[0]); end
    step();
    bus_b.go = 1'b0;
    @(negedge clk);
    total++; if (bus_b.violation !== 1'b1) begin bad++; $display("FAIL vc_set_wins got=%b want=1", bus_b.violation); end
    step();
    bus_b.clear_violation = 1'b0;
    @(negedge clk);
    total++; if (bus_b.violation !== 1'b0) begin bad++; $display("FAIL vc_cleared got=%b want=0", bus_b.violation); end
    step();
  endtask

  task automatic test_back_to_back();
    bit exp_done [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int exp_inf  [11] = '{0, 1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
    for (int c = 0; c < 11; c++) begin
      bus_a.go = (c <= 5);
      @(negedge clk);
      total++; if (bus_a.done !== exp_done[c]) begin bad++; $display("FAIL b2b_done c%0d got=%b want=%b", c, bus_a.done, exp_done[c]); end
      total++; if (bus_a.inflight !== 3'(exp_inf[c])) begin bad++; $display("FAIL b2b_inflight c%0d got=%0d want=%0d", c, bus_a.inflight, exp_inf[c]); end
      total++; if (bus_a.violation !== 1'b0) begin bad++; $display("FAIL b2b_viol c%0d got=%b want=0", c, bus_a.violation); end
      if (c == 4) begin
        total++; if (bus_a.en !== 4'hF) begin bad++; $display("FAIL b2b_en_full got=%h want=f", bus_a.en); end
      end
      step();
    end
    bus_a.go = 1'b0;
  endtask

  task automatic test_depth1();
    bit exp_acc  [5] = '{1, 0, 1, 0, 0};
    bit exp_done [5] = '{0, 1, 0, 1, 0};
    bit exp_viol [5] = '{0, 0, 1, 1, 1};
    bit exp_rdy  [5] = '{1, 0, 1, 0, 1};
    bit exp_inf  [5] = '{0, 1, 0, 1, 0};
    for (int c = 0; c < 5; c++) begin
      bus_c.go = (c <= 3);
      @(negedge clk);
      total++; if (bus_c.en[0] !== exp_acc[c]) begin bad++; $display("FAIL d1_en c%0d got=%b want=%b", c, bus_c.en[0], exp_acc[c]); end
      total++; if (bus_c.done !== exp_done[c]) begin bad++; $display("FAIL d1_done c%0d got=%b want=%b", c, bus_c.done, exp_done[c]); end
      total++; if (bus_c.violation !== exp_viol[c]) begin bad++; $display("FAIL d1_viol c%0d got=%b want=%b", c, bus_c.violation, exp_viol[c]); end
      total++; if (bus_c.ready !== exp_rdy[c]) begin bad++; $display("FAIL d1_ready c%0d got=%b want=%b", c, bus_c.ready, exp_rdy[c]); end
      total++; if (bus_c.inflight !== exp_inf[c]) begin bad++; $display("FAIL d1_inflight c%0d got=%0d want=%0d", c, bus_c.inflight, exp_inf[c]); end
      step();
    end
    bus_c.go = 1'b0;
  endtask

  task automatic test_mid_reset();
    bus_a.go = 1'b1;
    @(negedge clk);
    total++; if (bus_a.en !== 4'h1) begin bad++; $display("FAIL mr_en_c0 got=%h want=1", bus_a.en); end
    step();
    bus_a.go = 1'b0;
    @(negedge clk);
    total++; if (bus_a.en !== 4'h2) begin bad++; $display("FAIL mr_en_c1 got=%h want=2", bus_a.en); end
    step();
    bus_a.go = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    total++; if (bus_a.en !== 4'h0) begin bad++; $display("FAIL mr_en_c2 got=%h want=0", bus_a.en); end
    total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL mr_done_c2 got=%b want=0", bus_a.done); end
    total++; if (bus_a.ready !== 1'b0) begin bad++; $display("FAIL mr_ready_c2 got=%b want=0", bus_a.ready); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL mr_busy_c2 got=%b want=0", bus_a.busy); end
    step();
    bus_a.go = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    total++; if (bus_a.inflight !== 3'd0) begin bad++; $display("FAIL mr_inflight_c3 got=%0d want=0", bus_a.inflight); end
    total++; if (bus_a.ready !== 1'b1) begin bad++; $display("FAIL mr_ready_c3 got=%b want=1", bus_a.ready); end
    total++; if (bus_a.violation !== 1'b0) begin bad++; $display("FAIL mr_viol_c3 got=%b want=0", bus_a.violation); end
    for (int c = 3; c < 7; c++) begin
      total++; if (bus_a.en !== 4'h0) begin bad++; $display("FAIL mr_en_c%0d got=%h want=0", c, bus_a.en); end
      total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL mr_done_c%0d got=%b want=0", c, bus_a.done); end
      step();
      @(negedge clk);
    end
    step();
  endtask

  initial begin
    reset                 = 1'b1;
    bus_a.go              = 1'b0;
    bus_a.clear_violation = 1'b0;
    bus_b.go              = 1'b0;
    bus_b.clear_violation = 1'b0;
    bus_c.go              = 1'b0;
    bus_c.clear_violation = 1'b0;
    test_reset();
    test_single_token();
    test_ii_spacing();
    test_violation_clear();
    test_back_to_back();
    test_depth1();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
